// File: rtl/turf_pkg.sv
// -----------------------------------------------------------------------------
// turf_pkg
// Shared definitions for the turf-painting scorer and related display logic:
// default grid geometry, the "unpainted" colour code, the player-to-colour
// mapping and the scorer FSM state encoding.
// -----------------------------------------------------------------------------
package turf_pkg;

  localparam int DEF_X_BITS = 8;
  localparam int DEF_Y_BITS = 7;
  localparam int DEF_X_MAX  = 157;
  localparam int DEF_Y_MAX  = 119;

  // RAM cell value meaning "nobody painted here"
  localparam int COLOR_NONE = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SCAN    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } turf_state_t;

  // Player i paints cells with colour i+1 (colour 0 is reserved for unpainted)
  function automatic int unsigned player_color(input int unsigned player);
    return player + 1;
  endfunction

endpackage

// File: rtl/turf_raster_addr.sv
// -----------------------------------------------------------------------------
// turf_raster_addr
// Column-major raster counter over the paint grid: y advances first, and on
// wrapping past Y_MAX the x column advances. Wraps back to {0,0} after the
// last cell.
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-high reset
//   i_clear    synchronous return to {0,0}
//   i_advance  step to the next cell
//   o_x, o_y   current cell coordinate
//   o_last     current cell is {X_MAX,Y_MAX}
// -----------------------------------------------------------------------------
module turf_raster_addr
  import turf_pkg::*;
#(
  parameter int X_BITS = DEF_X_BITS,
  parameter int Y_BITS = DEF_Y_BITS,
  parameter int X_MAX  = DEF_X_MAX,
  parameter int Y_MAX  = DEF_Y_MAX
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [X_BITS-1:0] o_x,
  output logic [Y_BITS-1:0] o_y,
  output logic              o_last
);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic              w_x_end;
  logic              w_y_end;

  assign w_x_end = (r_x == X_BITS'(X_MAX));
  assign w_y_end = (r_y == Y_BITS'(Y_MAX));
  assign o_last  = w_x_end & w_y_end;
  assign o_x     = r_x;
  assign o_y     = r_y;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_y_end) begin
        r_y <= '0;
        r_x <= w_x_end ? '0 : r_x + X_BITS'(1);
      end else begin
        r_y <= r_y + Y_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/turf_tally.sv
// -----------------------------------------------------------------------------
// turf_tally
// End-of-round scorer. On start it clears its tallies, raster-scans the paint
// RAM, counts cells per player plus unpainted/foreign cells, then sweeps the
// player counts to find the lowest-index leader and whether the lead is shared.
// Ports:
//   CLOCK_50       clock (rising edge)
//   reset          asynchronous active-high reset
//   start          scan request, accepted in IDLE or DONE
//   busy           scan in progress
//   done           one-cycle pulse when results become valid
//   results_valid  results stable until the next accepted start
//   rd_en/rd_addr  paint RAM read port, address {x,y}
//   rd_data        paint RAM data, RD_LATENCY cycles after rd_en/rd_addr
//   counts         per-player counts, player i at [i*CNT_BITS +: CNT_BITS]
//   unpainted      cells with colour 0 or above NUM_PLAYERS
//   winner/tie     lowest index holding the max count / max shared
// -----------------------------------------------------------------------------
module turf_tally
  import turf_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int X_BITS      = DEF_X_BITS,
  parameter int Y_BITS      = DEF_Y_BITS,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int COLOR_BITS  = 3,
  parameter int CNT_BITS    = 15,
  parameter int RD_LATENCY  = 1
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             results_valid,
  output logic                             rd_en,
  output logic [X_BITS+Y_BITS-1:0]         rd_addr,
  input  logic [COLOR_BITS-1:0]            rd_data,
  output logic [NUM_PLAYERS*CNT_BITS-1:0]  counts,
  output logic [CNT_BITS-1:0]              unpainted,
  output logic [$clog2(NUM_PLAYERS)-1:0]   winner,
  output logic                             tie
);

  localparam int W_BITS = $clog2(NUM_PLAYERS);

  generate
    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 7 || RD_LATENCY < 1 || RD_LATENCY > 3 ||
        X_MAX >= (1 << X_BITS) || Y_MAX >= (1 << Y_BITS) ||
        NUM_PLAYERS >= (1 << COLOR_BITS)) begin : g_bad_params
      $error("turf_tally: illegal parameter combination");
    end
  endgenerate

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  turf_state_t                              r_state;
  logic                                     r_busy;
  logic                                     r_done;
  logic                                     r_rv;
  logic                                     r_rd_en;
  logic [1:0]                               r_drain;
  logic [W_BITS-1:0]                        r_idx;
  logic [CNT_BITS-1:0]                      r_max;
  logic [W_BITS-1:0]                        r_winner;
  logic                                     r_tie;
  logic [NUM_PLAYERS-1:0][CNT_BITS-1:0]     r_counts;
  logic [CNT_BITS-1:0]                      r_unp;
  logic [RD_LATENCY-1:0]                    r_vld;

  logic [X_BITS-1:0]                        w_x;
  logic [Y_BITS-1:0]                        w_y;
  logic                                     w_last;
  logic                                     w_accept;
  logic [NUM_PLAYERS-1:0]                   w_hit;
  logic [CNT_BITS-1:0]                      w_cur;

  turf_raster_addr #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS),
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX)
  ) u_raster (
    .i_clk     (CLOCK_50),
    .i_rst     (reset),
    .i_clear   (r_state == ST_CLEAR),
    .i_advance (r_state == ST_SCAN),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_last    (w_last)
  );

  assign rd_addr       = {w_x, w_y};
  assign rd_en         = r_rd_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign results_valid = r_rv;
  assign counts        = r_counts;
  assign unpainted     = r_unp;
  assign winner        = r_winner;
  assign tie           = r_tie;

  // ---- stage: read-issue valid delayed to line up with rd_data ----
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= r_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  assign w_accept = r_vld[RD_LATENCY-1];

  // Exactly one player matches a given colour; anything unmatched
  // (colour 0 or beyond the last player) counts as unpainted.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      w_hit[i] = (rd_data == COLOR_BITS'(player_color(i)));
  end

  // ---- stage: accumulate returned cells ----
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_counts <= '0;
      r_unp    <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_counts <= '0;
      r_unp    <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_PLAYERS; i++)
        if (w_hit[i]) r_counts[i] <= sat_inc(r_counts[i]);
      if (!(|w_hit)) r_unp <= sat_inc(r_unp);
    end
  end

  assign w_cur = r_counts[r_idx];

  // ---- stage: control FSM and leader sweep ----
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rv     <= 1'b0;
      r_rd_en  <= 1'b0;
      r_drain  <= '0;
      r_idx    <= '0;
      r_max    <= '0;
      r_winner <= '0;
      r_tie    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_rv    <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_state  <= ST_SCAN;
          r_rd_en  <= 1'b1;
          r_drain  <= '0;
          r_idx    <= '0;
          r_max    <= '0;
          r_winner <= '0;
          r_tie    <= 1'b0;
        end
        ST_SCAN: begin
          if (w_last) begin
            r_state <= ST_DRAIN;
            r_rd_en <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (r_drain == 2'(RD_LATENCY - 1)) r_state <= ST_COMPARE;
          else                               r_drain <= r_drain + 2'd1;
        end
        ST_COMPARE: begin
          // Strict '>' keeps the lowest index on equal counts; an equal
          // count after the first player marks the lead as shared.
          if (w_cur > r_max) begin
            r_max    <= w_cur;
            r_winner <= r_idx;
            r_tie    <= 1'b0;
          end else if (w_cur == r_max && r_idx != '0) begin
            r_tie <= 1'b1;
          end
          if (r_idx == W_BITS'(NUM_PLAYERS - 1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_rv    <= 1'b1;
          end else begin
            r_idx <= r_idx + W_BITS'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turf_tally.sv
// -----------------------------------------------------------------------------
// tb_turf_tally
// Four scorer instances: default geometry (RAM tied to unpainted), a 4x2 grid
// with latency 1, a 4x2 grid with latency 3, and a 4x2 grid with 2-bit
// counters. The small grids share one behavioural RAM image. Expected results
// come from a reference model of the scoring rules, queued when a scan is
// started and checked when done is seen.
// -----------------------------------------------------------------------------
module tb_turf_tally;
  import turf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] mem [8];

  // default instance
  logic        d_start, d_busy, d_done, d_rv, d_rden, d_tie;
  logic [14:0] d_addr, d_unp;
  logic [2:0]  d_data;
  logic [59:0] d_counts;
  logic [1:0]  d_win;
  // small grid, latency 1
  logic        s_start, s_busy, s_done, s_rv, s_rden, s_tie;
  logic [14:0] s_addr, s_unp;
  logic [2:0]  s_data, s_p;
  logic [59:0] s_counts;
  logic [1:0]  s_win;
  // small grid, latency 3
  logic        l_start, l_busy, l_done, l_rv, l_rden, l_tie;
  logic [14:0] l_addr, l_unp;
  logic [2:0]  l_data, l_p0, l_p1, l_p2;
  logic [59:0] l_counts;
  logic [1:0]  l_win;
  // small grid, 2-bit counters
  logic        t_start, t_busy, t_done, t_rv, t_rden, t_tie;
  logic [14:0] t_addr;
  logic [1:0]  t_unp;
  logic [2:0]  t_data, t_p;
  logic [7:0]  t_counts;
  logic [1:0]  t_win;

  assign d_data = 3'(COLOR_NONE);

  turf_tally u_def (
    .CLOCK_50(clk), .reset(rst), .start(d_start), .busy(d_busy), .done(d_done),
    .results_valid(d_rv), .rd_en(d_rden), .rd_addr(d_addr), .rd_data(d_data),
    .counts(d_counts), .unpainted(d_unp), .winner(d_win), .tie(d_tie));

  turf_tally #(.X_MAX(3), .Y_MAX(1)) u_sm (
    .CLOCK_50(clk), .reset(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .results_valid(s_rv), .rd_en(s_rden), .rd_addr(s_addr), .rd_data(s_data),
    .counts(s_counts), .unpainted(s_unp), .winner(s_win), .tie(s_tie));

  turf_tally #(.X_MAX(3), .Y_MAX(1), .RD_LATENCY(3)) u_l3 (
    .CLOCK_50(clk), .reset(rst), .start(l_start), .busy(l_busy), .done(l_done),
    .results_valid(l_rv), .rd_en(l_rden), .rd_addr(l_addr), .rd_data(l_data),
    .counts(l_counts), .unpainted(l_unp), .winner(l_win), .tie(l_tie));

  turf_tally #(.X_MAX(3), .Y_MAX(1), .CNT_BITS(2)) u_st (
    .CLOCK_50(clk), .reset(rst), .start(t_start), .busy(t_busy), .done(t_done),
    .results_valid(t_rv), .rd_en(t_rden), .rd_addr(t_addr), .rd_data(t_data),
    .counts(t_counts), .unpainted(t_unp), .winner(t_win), .tie(t_tie));

  // Behavioural RAMs: cell index = x*2 + y for the 4x2 grid
  always_ff @(posedge clk) begin
    s_p  <= mem[{s_addr[8:7], s_addr[0]}];
    t_p  <= mem[{t_addr[8:7], t_addr[0]}];
    l_p0 <= mem[{l_addr[8:7], l_addr[0]}];
    l_p1 <= l_p0;
    l_p2 <= l_p1;
  end
  assign s_data = s_p;
  assign t_data = t_p;
  assign l_data = l_p2;

  // Observation of the latency-1 small instance: address log and done pulses
  logic [14:0] s_cap [256];
  int          s_ncap = 0;
  int          s_dn   = 0;
  always @(posedge clk) begin
    if (s_rden && s_ncap < 256) begin
      s_cap[s_ncap] <= s_addr;
      s_ncap        <= s_ncap + 1;
    end
    if (s_done) s_dn <= s_dn + 1;
  end

  typedef struct {
    int c0, c1, c2, c3, unp, win, tie, lat;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  int   a_cnt [4];
  int   a_unp, a_win, a_tie, a_busy, a_done, a_rv, a_rden, a_addr;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample(input int inst);
    case (inst)
      0: begin
        for (int p = 0; p < 4; p++) a_cnt[p] = int'(d_counts[p*15 +: 15]);
        a_unp = int'(d_unp); a_win = int'(d_win); a_tie = int'(d_tie);
        a_busy = int'(d_busy); a_done = int'(d_done); a_rv = int'(d_rv);
        a_rden = int'(d_rden); a_addr = int'(d_addr);
      end
      1: begin
        for (int p = 0; p < 4; p++) a_cnt[p] = int'(s_counts[p*15 +: 15]);
        a_unp = int'(s_unp); a_win = int'(s_win); a_tie = int'(s_tie);
        a_busy = int'(s_busy); a_done = int'(s_done); a_rv = int'(s_rv);
        a_rden = int'(s_rden); a_addr = int'(s_addr);
      end
      2: begin
        for (int p = 0; p < 4; p++) a_cnt[p] = int'(l_counts[p*15 +: 15]);
        a_unp = int'(l_unp); a_win = int'(l_win); a_tie = int'(l_tie);
        a_busy = int'(l_busy); a_done = int'(l_done); a_rv = int'(l_rv);
        a_rden = int'(l_rden); a_addr = int'(l_addr);
      end
      default: begin
        for (int p = 0; p < 4; p++) a_cnt[p] = int'(t_counts[p*2 +: 2]);
        a_unp = int'(t_unp); a_win = int'(t_win); a_tie = int'(t_tie);
        a_busy = int'(t_busy); a_done = int'(t_done); a_rv = int'(t_rv);
        a_rden = int'(t_rden); a_addr = int'(t_addr);
      end
    endcase
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       d_start = v;
      1:       s_start = v;
      2:       l_start = v;
      default: t_start = v;
    endcase
  endtask

  // Reference scoring: tally the RAM image, clamp at the counter ceiling,
  // leader = lowest index with the maximum, tie = maximum held by 2+ players.
  function automatic exp_t model(input int ncells, input bit use_mem,
                                 input int cmax, input int lat);
    exp_t e;
    int   n [4];
    int   u, mx, nmax, w;
    n = '{0, 0, 0, 0};
    u = 0;
    for (int i = 0; i < ncells; i++) begin
      int d;
      d = use_mem ? int'(mem[i]) : 0;
      if (d >= 1 && d <= 4) n[d-1]++;
      else                  u++;
    end
    for (int k = 0; k < 4; k++) if (n[k] > cmax) n[k] = cmax;
    if (u > cmax) u = cmax;
    mx = 0;
    for (int k = 0; k < 4; k++) if (n[k] > mx) mx = n[k];
    nmax = 0;
    w    = 0;
    for (int k = 3; k >= 0; k--) if (n[k] == mx) begin nmax++; w = k; end
    e.c0 = n[0]; e.c1 = n[1]; e.c2 = n[2]; e.c3 = n[3];
    e.unp = u;
    e.win = w;
    e.tie = (nmax >= 2) ? 1 : 0;
    e.lat = 1 + ncells + lat + 4;
    return e;
  endfunction

  task automatic run_scan(input int inst, input string tag, input exp_t e, input bit noise);
    exp_t x;
    int   edges;
    bit   got;
    sbq.push_back(e);
    @(posedge clk); #1 set_start(inst, 1'b1);
    @(posedge clk); #1 set_start(inst, 1'b0);
    sample(inst);
    chk({tag, "/clear_busy"}, a_busy, 1);
    chk({tag, "/clear_rv"}, a_rv, 0);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < e.lat + 20) begin
      @(posedge clk);
      edges++;
      #1;
      set_start(inst, (noise && (edges == 3 || edges == 5)) ? 1'b1 : 1'b0);
      sample(inst);
      if (a_done == 1) got = 1'b1;
    end
    x = sbq.pop_front();
    chk({tag, "/done_seen"}, int'(got), 1);
    chk({tag, "/latency"}, edges, x.lat);
    chk({tag, "/cnt0"}, a_cnt[0], x.c0);
    chk({tag, "/cnt1"}, a_cnt[1], x.c1);
    chk({tag, "/cnt2"}, a_cnt[2], x.c2);
    chk({tag, "/cnt3"}, a_cnt[3], x.c3);
    chk({tag, "/unpainted"}, a_unp, x.unp);
    chk({tag, "/winner"}, a_win, x.win);
    chk({tag, "/tie"}, a_tie, x.tie);
    chk({tag, "/rv"}, a_rv, 1);
    chk({tag, "/busy"}, a_busy, 0);
    @(posedge clk); #1 sample(inst);
    chk({tag, "/done_pulse"}, a_done, 0);
    chk({tag, "/rv_hold"}, a_rv, 1);
  endtask

  initial begin
    int   base;
    int   s_runs;
    exp_t e;
    s_runs  = 0;
    rst     = 1'b1;
    d_start = 1'b0; s_start = 1'b0; l_start = 1'b0; t_start = 1'b0;
    mem     = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      sample(i);
      chk($sformatf("rst%0d/busy", i), a_busy, 0);
      chk($sformatf("rst%0d/done", i), a_done, 0);
      chk($sformatf("rst%0d/rv", i), a_rv, 0);
      chk($sformatf("rst%0d/rden", i), a_rden, 0);
      chk($sformatf("rst%0d/cnt0", i), a_cnt[0], 0);
      chk($sformatf("rst%0d/winner_tie", i), a_win + a_tie, 0);
    end
    @(negedge clk) rst = 1'b0;

    // Default geometry, RAM all unpainted
    e = model(18960, 1'b0, 32767, 1);
    run_scan(0, "default", e, 1'b0);

    // Distinct owners, check address order too
    mem  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0};
    base = s_ncap;
    e    = model(8, 1'b1, 32767, 1);
    run_scan(1, "mixed", e, 1'b0);
    s_runs++;
    chk("mixed/addr_count", s_ncap - base, 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("mixed/addr%0d", k), int'(s_cap[base + k]), (k / 2) * 128 + (k % 2));

    // Shared lead, with extra start pulses while busy
    mem = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    e   = model(8, 1'b1, 32767, 1);
    run_scan(1, "tie_noise", e, 1'b1);
    s_runs++;

    // Out-of-range colour 7 lands in unpainted
    mem = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd7, 3'd0, 3'd7, 3'd1};
    e   = model(8, 1'b1, 32767, 1);
    run_scan(1, "color7", e, 1'b0);
    s_runs++;
    repeat (10) @(posedge clk);
    #1 chk("sm/done_pulses", s_dn, s_runs);

    // Latency 3, every cell player 0
    mem = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    e   = model(8, 1'b1, 32767, 3);
    run_scan(2, "lat3", e, 1'b0);

    // 2-bit counters saturate
    e = model(8, 1'b1, 3, 1);
    run_scan(3, "sat", e, 1'b0);

    // Reset in the middle of a scan, then a clean rescan
    mem = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0};
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 sample(1);
    chk("midrst/busy", a_busy, 0);
    chk("midrst/rden", a_rden, 0);
    chk("midrst/addr", a_addr, 0);
    chk("midrst/cnt0", a_cnt[0], 0);
    chk("midrst/rv", a_rv, 0);
    chk("midrst/state", int'(u_sm.r_state), int'(ST_IDLE));
    @(negedge clk) rst = 1'b0;
    e = model(8, 1'b1, 32767, 1);
    run_scan(1, "after_rst", e, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/turf_tally.md
Name: turf_tally

Overview:
- Parametrised end-of-round scorer for the turf-painting game. After movement stops, it raster-scans the paint RAM, counts cells per player plus unpainted cells, and resolves a winner with explicit tie reporting.
- Sits between the paint RAM read port and the score/winner display logic.
- Supports any player count, grid size, colour width and RAM read latency, with a start/busy/done handshake.

Parameters:
- NUM_PLAYERS, 4, number of players; legal range 2..7.
- X_BITS, 8, width of the x coordinate (address upper field).
- Y_BITS, 7, width of the y coordinate (address lower field).
- X_MAX, 157, last scanned x column.
- Y_MAX, 119, last scanned y row.
- COLOR_BITS, 3, width of a RAM cell.
- CNT_BITS, 15, width of each per-player counter.
- RD_LATENCY, 1, RAM read latency in cycles; legal range 1..3.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  request a scan; sampled on a rising edge.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results become valid.
- results_valid  out  1  level; high from done until the next accepted start or reset.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  X_BITS+Y_BITS  RAM address, {x,y}.
- rd_data  in  COLOR_BITS  RAM cell; 0 = unpainted; value k (1..NUM_PLAYERS) = player k-1.
- counts  out  NUM_PLAYERS*CNT_BITS  per-player cell counts; player i occupies bits [i*CNT_BITS +: CNT_BITS].
- unpainted  out  CNT_BITS  cells equal to 0 or greater than NUM_PLAYERS.
- winner  out  clog2(NUM_PLAYERS)  lowest player index holding the maximum count.
- tie  out  1  high if two or more players share the maximum count.

Behaviour:
- Clock is CLOCK_50; reset is asynchronous, active-high.
- Reset value of every output and register is 0; the FSM resets to IDLE.
- Reset asserted mid-scan aborts the scan immediately; no partial result is retained.
- FSM states: IDLE, CLEAR, SCAN, DRAIN, COMPARE, DONE.
- IDLE or DONE with start=1 -> CLEAR. In all other states start is ignored (no queuing).
- CLEAR (1 cycle):
  - zero all counts and unpainted;
  - x=0, y=0;
  - results_valid=0, busy=1.
- SCAN (N_CELLS=(X_MAX+1)*(Y_MAX+1) cycles):
  - rd_en=1 and rd_addr={x,y} every cycle;
  - y increments first; at Y_MAX, y wraps to 0 and x increments;
  - after address {X_MAX,Y_MAX} -> DRAIN.
- Read pipeline:
  - a valid bit per issued read is delayed RD_LATENCY cycles;
  - rd_data is accepted only when the delayed valid is high;
  - each accepted cell increments exactly one counter.
- DRAIN (RD_LATENCY cycles): rd_en=0; outstanding reads are retired.
- COMPARE (NUM_PLAYERS cycles): sequential sweep over i=0..N-1 with a running max.
  - count > max: max=count, winner=i, tie=0.
  - count == max and i>0: tie=1.
  - Result: the lowest index wins; all-zero counts give winner=0, tie=1.
- DONE:
  - done pulses in the first DONE cycle only;
  - results_valid=1, busy=0;
  - counts, winner and tie hold until the next start or reset.
- Latency: done is high in the cycle following the edge that is 1+N_CELLS+RD_LATENCY+NUM_PLAYERS edges after the edge sampling start. Default: 18966.
- Width rules:
  - counters saturate at 2^CNT_BITS-1 and never wrap;
  - X_MAX < 2^X_BITS and Y_MAX < 2^Y_BITS are required; an elaboration-time check is acceptable.
- start held high through DONE restarts a scan one cycle after done; results_valid drops in CLEAR.

Decomposition:
- Shared package turf_pkg holds:
  - default grid constants X_MAX/Y_MAX/X_BITS/Y_BITS;
  - COLOR_NONE=0;
  - the player-to-colour function (player i -> i+1);
  - the FSM state enum.
- Sub-module turf_raster_addr: x/y raster counter.
  - Inputs: clear, advance.
  - Outputs: {x,y} and a last flag.
  - Reused later by the VGA redraw path.

Test Plan:
- Default params, RAM all 0, start pulse -> done 18966 edges later; counts all 0; unpainted=18960; winner=0; tie=1.
- X_MAX=3, Y_MAX=1, RAM {1,1,2,3,4,4,4,0}:
  - rd_addr sequence is 0,1,128,129,256,257,384,385;
  - counts={1:2,2:1,3:1,4:3}, unpainted=1, winner=3, tie=0.
- Small grid, RAM {2,2,3,3,0,0,0,0} -> winner=1, tie=1; cell value 7 with NUM_PLAYERS=4 is counted in unpainted.
- RD_LATENCY=3, small grid all cells=1 -> p0 count=8 (no dropped or duplicated reads); done at 1+8+3+4=16 edges.
- Reset asserted mid-SCAN -> outputs 0 and state IDLE on the same edge; a fresh start then gives correct counts.
- start pulses during busy are ignored (single done); CNT_BITS=2 with 8 cells of player 1 -> count saturates at 3.
